// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control interface.
// Groups the hazard-detection inputs and the pipeline-register control outputs
// that connect the hazard controller to the pipeline datapath.
//   master : datapath side (drives hazard status, receives enables/flushes/status)
//   slave  : controller side (receives hazard status, drives enables/flushes/status)
// Signals:
//   ihit, dhit, exmem_dREN, exmem_dWEN, idex_memToReg, idex_regWr,
//   idex_rd[4:0], ifid_rs[4:0], ifid_rt[4:0], branch_taken, memwb_halt  (to controller)
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
//   halted, mem_timeout, stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0]     (from controller)
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             idex_memToReg;
    logic             idex_regWr;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             branch_taken;
    logic             memwb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_memToReg, idex_regWr,
               idex_rd, ifid_rs, ifid_rt, branch_taken, memwb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
               halted, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_memToReg, idex_regWr,
               idex_rd, ifid_rs, ifid_rt, branch_taken, memwb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
               halted, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves icache misses, dcache waits and load-use hazards (stalls), taken
// branches/jumps (flushes) and HALT retirement (permanent freeze). Keeps
// saturating stall/flush performance counters and a sticky dcache-wait timeout.
// Ports:
//   clk    : clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : pipeline_hazard_ctrl_if.slave (hazard inputs, enables/flushes,
//            halted, mem_timeout, stall_cnt, flush_cnt)
// Parameters:
//   CNT_W   : performance counter width (must match the interface CNT_W)
//   TIMEOUT : consecutive DWAIT cycles before mem_timeout; 0 disables the check
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    n_rst,
    pipeline_hazard_ctrl_if.slave   bus
);
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

    state_t            state, state_next;
    logic              mem_stl;
    logic              load_use;
    logic              pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
    logic [WAIT_W-1:0] wait_cnt, wait_inc;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_q, flush_q;

    always_comb begin
        mem_stl  = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
        load_use = bus.idex_memToReg & bus.idex_regWr & (bus.idex_rd != 5'd0) &
                   ((bus.idex_rd == bus.ifid_rs) | (bus.idex_rd == bus.ifid_rt));

        state_next = state;
        case (state)
            RUN:     if (bus.memwb_halt) state_next = HALT;
                     else if (mem_stl)   state_next = DWAIT;
            DWAIT:   if (bus.memwb_halt) state_next = HALT;
                     else if (!mem_stl)  state_next = RUN;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase

        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_flush_c = 1'b0;
        // A retiring halt must not be overwritten, so it kills every enable now.
        if (state != HALT && !bus.memwb_halt) begin
            idex_en_c    = ~mem_stl;
            idex_flush_c = ~mem_stl & (bus.branch_taken | load_use);
            ifid_en_c    = ~mem_stl & ~load_use & bus.ihit;
            ifid_flush_c = ~mem_stl & (bus.branch_taken | (~bus.ihit & ~load_use));
            pc_en_c      = ~mem_stl & (bus.branch_taken | (bus.ihit & ~load_use));
        end

        wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

        // Reset holds every pipeline register still while it is asserted.
        bus.pc_en      = n_rst & pc_en_c;
        bus.ifid_en    = n_rst & ifid_en_c;
        bus.ifid_flush = n_rst & ifid_flush_c;
        bus.idex_en    = n_rst & idex_en_c;
        bus.idex_flush = n_rst & idex_flush_c;
        bus.exmem_en   = n_rst & idex_en_c;
        bus.memwb_en   = n_rst & idex_en_c;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state <= state_next;
            if (state != HALT) begin
                if (!pc_en_c && stall_q != '1)
                    stall_q <= stall_q + 1'b1;
                if ((ifid_flush_c || idex_flush_c) && flush_q != '1)
                    flush_q <= flush_q + 1'b1;
            end
            // The wait count saturates at TIMEOUT; the cycle that reaches it
            // raises the flag even if the access completes in that cycle.
            if (state == DWAIT) begin
                if (TIMEOUT != 0 && wait_inc == WAIT_MAX)
                    timeout_q <= 1'b1;
                wait_cnt <= (state_next == DWAIT) ? wait_inc : '0;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign bus.halted      = (state == HALT);
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step drives inputs, pushes the
// expected outputs from a behavioural model into a scoreboard queue, then pops
// and compares before the next rising edge.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned CW = 8;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [6:0] ctl;   // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en}
        logic       halted;
        logic       tmo;
        logic [7:0] stall;
        logic [7:0] flush;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // stimulus
    logic       i_ihit, i_dhit, i_dren, i_dwen, i_m2r, i_rw, i_br, i_halt;
    logic [4:0] i_rd, i_rs, i_rt;

    // model state: 0 RUN, 1 DWAIT, 2 HALT
    int m_state = 0;
    int m_wait  = 0;
    int m_tmo   = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input string fld,
                         input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    endtask

    task automatic clear_inputs();
        i_ihit = 1'b1; i_dhit = 1'b0; i_dren = 1'b0; i_dwen = 1'b0;
        i_m2r = 1'b0; i_rw = 1'b0; i_br = 1'b0; i_halt = 1'b0;
        i_rd = 5'd0; i_rs = 5'd0; i_rt = 5'd0;
    endtask

    task automatic step(input string tag);
        exp_t e, got;
        bit   stl, lu, pc, fe, ff, xe, xf;
        int   ns, inc;
        bus.ihit = i_ihit; bus.dhit = i_dhit; bus.exmem_dREN = i_dren;
        bus.exmem_dWEN = i_dwen; bus.idex_memToReg = i_m2r; bus.idex_regWr = i_rw;
        bus.idex_rd = i_rd; bus.ifid_rs = i_rs; bus.ifid_rt = i_rt;
        bus.branch_taken = i_br; bus.memwb_halt = i_halt;

        if (!n_rst) begin
            m_state = 0; m_wait = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
        end
        e.tag = tag;
        e.halted = (m_state == 2);
        e.tmo = (m_tmo != 0);
        e.stall = 8'(m_stall);
        e.flush = 8'(m_flush);

        stl = (i_dren | i_dwen) & ~i_dhit;
        lu  = i_m2r & i_rw & (i_rd != 0) & ((i_rd == i_rs) | (i_rd == i_rt));
        pc = 0; fe = 0; ff = 0; xe = 0; xf = 0;
        if (n_rst && m_state != 2 && !i_halt && !stl) begin
            xe = 1;
            fe = ~lu & i_ihit;
            if (i_br)        begin pc = 1; ff = 1; xf = 1; end
            else if (lu)     xf = 1;
            else if (!i_ihit) ff = 1;
            else             pc = 1;
        end
        e.ctl = {pc, fe, ff, xe, xf, xe, xe};
        sb.push_back(e);

        if (n_rst) begin
            ns = m_state;
            if (m_state != 2) begin
                if (i_halt) ns = 2;
                else ns = stl ? 1 : 0;
                if (!pc && m_stall < 255) m_stall++;
                if ((ff || xf) && m_flush < 255) m_flush++;
            end
            if (m_state == 1) begin
                inc = (m_wait < int'(TO)) ? m_wait + 1 : m_wait;
                if (inc == int'(TO)) m_tmo = 1;
                m_wait = (ns == 1) ? inc : 0;
            end else begin
                m_wait = 0;
            end
            m_state = ns;
        end

        #3;
        got = sb.pop_front();
        check(got.tag, "ctl", {25'd0, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                               bus.idex_flush, bus.exmem_en, bus.memwb_en}, {25'd0, got.ctl});
        check(got.tag, "halted", {31'd0, bus.halted}, {31'd0, got.halted});
        check(got.tag, "mem_timeout", {31'd0, bus.mem_timeout}, {31'd0, got.tmo});
        check(got.tag, "stall_cnt", {24'd0, bus.stall_cnt}, {24'd0, got.stall});
        check(got.tag, "flush_cnt", {24'd0, bus.flush_cnt}, {24'd0, got.flush});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        @(posedge clk);
        #1;
        step("reset0");
        step("reset1");
        n_rst = 1'b1;

        // free running, no hazards
        for (int i = 0; i < 10; i++) step("run");

        // dcache wait of three cycles
        i_dren = 1'b1; i_dhit = 1'b0;
        for (int i = 0; i < 3; i++) step("dwait");
        i_dhit = 1'b1;
        step("dhit");
        clear_inputs();
        step("after_dwait");

        // load-use on rt, then rd==0, then rs match
        i_m2r = 1'b1; i_rw = 1'b1; i_rd = 5'd5; i_rt = 5'd5;
        step("load_use_rt");
        i_rd = 5'd0; i_rt = 5'd0;
        step("load_use_r0");
        i_rd = 5'd7; i_rs = 5'd7;
        step("load_use_rs");
        i_rw = 1'b0;
        step("load_no_regwr");

        // branch beats load-use and icache miss
        i_rw = 1'b1; i_ihit = 1'b0; i_br = 1'b1;
        step("br_lu_miss");
        clear_inputs();
        i_ihit = 1'b0;
        step("imiss");
        i_br = 1'b1; i_ihit = 1'b1;
        step("br_hit");
        i_dwen = 1'b1;
        step("stl_over_br");
        clear_inputs();
        step("idle");

        // flush counter saturation
        i_br = 1'b1;
        for (int i = 0; i < 260; i++) step("flush_sat");
        clear_inputs();
        step("flush_sat_done");

        // timeout, then asynchronous reset in the middle of the wait
        i_dren = 1'b1; i_dhit = 1'b0;
        for (int i = 0; i < 6; i++) step("timeout");
        n_rst = 1'b0;
        step("rst_mid_wait");
        step("rst_held");
        n_rst = 1'b1;
        step("rst_release_stl");
        clear_inputs();
        step("rst_release_run");

        // halt freezes everything
        i_halt = 1'b1;
        step("halt");
        for (int i = 0; i < 20; i++) begin
            i_ihit = 1'($urandom); i_dhit = 1'($urandom); i_dren = 1'($urandom);
            i_dwen = 1'($urandom); i_m2r = 1'($urandom); i_rw = 1'($urandom);
            i_br = 1'($urandom); i_halt = 1'($urandom);
            i_rd = 5'($urandom); i_rs = 5'($urandom); i_rt = 5'($urandom);
            step("halted_frozen");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
